// File: rtl/cfg_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : cfg_frame_loader_if
// Description : Bus bundle between the host bridge / serializer side and the
//               configuration frame loader.
//               Host/serializer side (master modport) drives:
//                   RX_DATA[7:0], RX_VALID, FLAG_DONE
//               Loader (slave modport) drives:
//                   RX_READY, DYN_CFG[15:0], STAT_CFG[87:0], SER_RST_N,
//                   FLAG_START, BUSY, FRAME_OK, FRAME_ERR, ERR_CODE[1:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface cfg_frame_loader_if;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        FLAG_DONE;
    logic [15:0] DYN_CFG;
    logic [87:0] STAT_CFG;
    logic        SER_RST_N;
    logic        FLAG_START;
    logic        BUSY;
    logic        FRAME_OK;
    logic        FRAME_ERR;
    logic [1:0]  ERR_CODE;

    modport master (
        output RX_DATA, RX_VALID, FLAG_DONE,
        input  RX_READY, DYN_CFG, STAT_CFG, SER_RST_N, FLAG_START,
               BUSY, FRAME_OK, FRAME_ERR, ERR_CODE
    );

    modport slave (
        input  RX_DATA, RX_VALID, FLAG_DONE,
        output RX_READY, DYN_CFG, STAT_CFG, SER_RST_N, FLAG_START,
               BUSY, FRAME_OK, FRAME_ERR, ERR_CODE
    );
endinterface
`default_nettype wire

// File: rtl/cfg_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_frame_loader
// Description : Receives a 16-byte configuration frame from the host bridge,
//               validates header/command/checksum, latches the DYNCNF and
//               STATCNF words, re-arms the serializer through SER_RST_N,
//               raises FLAG_START and waits for the synchronised done flag.
// Ports       : CLK  - system clock
//               RST  - asynchronous reset, active-high
//               bus  - cfg_frame_loader_if.slave (byte stream in, serializer
//                      control and status out)
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_frame_loader #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter logic [7:0]  CMD_LOAD       = 8'h01,
    parameter logic [15:0] DYN_INIT       = 16'hABC6,
    parameter logic [87:0] STAT_INIT      = 88'h123456789ABCDEF1234567,
    parameter int unsigned SER_RST_CYCLES = 16,
    parameter int unsigned BYTE_TIMEOUT   = 1024,
    parameter int unsigned DONE_TIMEOUT   = 4096
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    cfg_frame_loader_if.slave  bus
);

    localparam int c_GAP_W  = $clog2(BYTE_TIMEOUT) + 1;
    localparam int c_ARM_W  = $clog2(SER_RST_CYCLES) + 1;
    localparam int c_DONE_W = $clog2(DONE_TIMEOUT) + 1;

    localparam logic [c_GAP_W-1:0]  c_GAP_MAX  = c_GAP_W'(BYTE_TIMEOUT);
    localparam logic [c_ARM_W-1:0]  c_ARM_LAST = c_ARM_W'(SER_RST_CYCLES - 1);
    localparam logic [c_DONE_W-1:0] c_DONE_MAX = c_DONE_W'(DONE_TIMEOUT);
    // Index of the checksum byte among the 15 post-header bytes.
    localparam logic [3:0]          c_CHK_IDX  = 4'd14;

    localparam logic [1:0] c_ERR_OK      = 2'b00;
    localparam logic [1:0] c_ERR_CMD     = 2'b01;
    localparam logic [1:0] c_ERR_CHK     = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_CHECK = 3'd2,
        S_ARM   = 3'd3,
        S_START = 3'd4
    } state_t;

    state_t                r_state_q,      w_state_d;
    logic [3:0]            r_idx_q,        w_idx_d;
    logic [7:0]            r_xor_q,        w_xor_d;
    logic [111:0]          r_shift_q,      w_shift_d;
    logic [c_GAP_W-1:0]    r_gap_q,        w_gap_d;
    logic [c_ARM_W-1:0]    r_arm_q,        w_arm_d;
    logic [c_DONE_W-1:0]   r_done_cnt_q,   w_done_cnt_d;
    logic [1:0]            r_sync_q,       w_sync_d;
    logic [15:0]           r_dyn_cfg_q,    w_dyn_cfg_d;
    logic [87:0]           r_stat_cfg_q,   w_stat_cfg_d;
    logic                  r_rx_ready_q,   w_rx_ready_d;
    logic                  r_ser_rst_n_q,  w_ser_rst_n_d;
    logic                  r_flag_start_q, w_flag_start_d;
    logic                  r_frame_ok_q,   w_frame_ok_d;
    logic                  r_frame_err_q,  w_frame_err_d;
    logic [1:0]            r_err_code_q,   w_err_code_d;

    logic                  w_accept;
    logic                  w_done_s;

    assign w_accept = bus.RX_VALID && r_rx_ready_q;
    assign w_done_s = r_sync_q[1];

    // Shadow layout after 14 payload bytes: CMD | DYN[15:0] | STAT[87:0]
    // The running XOR also folds in CHK, so a good frame leaves it at zero.
    always_comb begin
        w_state_d    = r_state_q;
        w_idx_d      = r_idx_q;
        w_xor_d      = r_xor_q;
        w_shift_d    = r_shift_q;
        w_gap_d      = r_gap_q;
        w_arm_d      = r_arm_q;
        w_done_cnt_d = r_done_cnt_q;
        w_sync_d     = {r_sync_q[0], bus.FLAG_DONE};
        w_dyn_cfg_d  = r_dyn_cfg_q;
        w_stat_cfg_d = r_stat_cfg_q;
        w_frame_ok_d = 1'b0;
        w_frame_err_d = 1'b0;
        w_err_code_d = r_err_code_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept && (bus.RX_DATA == HEADER)) begin
                    w_state_d    = S_RECV;
                    w_idx_d      = 4'd0;
                    w_xor_d      = 8'h00;
                    w_gap_d      = '0;
                    w_err_code_d = c_ERR_OK;
                end
            end

            S_RECV: begin
                if (w_accept) begin
                    w_gap_d = '0;
                    w_xor_d = r_xor_q ^ bus.RX_DATA;
                    w_idx_d = r_idx_q + 4'd1;
                    if (r_idx_q == c_CHK_IDX) begin
                        w_state_d = S_CHECK;
                    end else begin
                        w_shift_d = {r_shift_q[103:0], bus.RX_DATA};
                    end
                end else if (r_gap_q == c_GAP_MAX) begin
                    w_state_d     = S_IDLE;
                    w_err_code_d  = c_ERR_TIMEOUT;
                    w_frame_err_d = 1'b1;
                end else begin
                    w_gap_d = r_gap_q + 1'b1;
                end
            end

            S_CHECK: begin
                if (r_shift_q[111:104] != CMD_LOAD) begin
                    w_state_d     = S_IDLE;
                    w_err_code_d  = c_ERR_CMD;
                    w_frame_err_d = 1'b1;
                end else if (r_xor_q != 8'h00) begin
                    w_state_d     = S_IDLE;
                    w_err_code_d  = c_ERR_CHK;
                    w_frame_err_d = 1'b1;
                end else begin
                    w_state_d    = S_ARM;
                    w_dyn_cfg_d  = r_shift_q[103:88];
                    w_stat_cfg_d = r_shift_q[87:0];
                    w_arm_d      = '0;
                end
            end

            S_ARM: begin
                // done_s is deliberately ignored while the serializer is held
                // in reset; its flag from the previous transfer may still be up.
                if (r_arm_q == c_ARM_LAST) begin
                    w_state_d    = S_START;
                    w_done_cnt_d = '0;
                end else begin
                    w_arm_d = r_arm_q + 1'b1;
                end
            end

            S_START: begin
                // Done is tested first so it wins over a coincident timeout.
                if (w_done_s) begin
                    w_state_d    = S_IDLE;
                    w_err_code_d = c_ERR_OK;
                    w_frame_ok_d = 1'b1;
                end else if (r_done_cnt_q == c_DONE_MAX) begin
                    w_state_d     = S_IDLE;
                    w_err_code_d  = c_ERR_TIMEOUT;
                    w_frame_err_d = 1'b1;
                end else begin
                    w_done_cnt_d = r_done_cnt_q + 1'b1;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // Handshake and serializer controls are registered from the next
        // state so they line up exactly with the state they belong to.
        w_rx_ready_d   = (w_state_d == S_IDLE) || (w_state_d == S_RECV);
        w_ser_rst_n_d  = (w_state_d != S_ARM);
        w_flag_start_d = (w_state_d == S_START);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state_q      <= S_IDLE;
            r_idx_q        <= 4'd0;
            r_xor_q        <= 8'h00;
            r_shift_q      <= '0;
            r_gap_q        <= '0;
            r_arm_q        <= '0;
            r_done_cnt_q   <= '0;
            r_sync_q       <= 2'b00;
            r_dyn_cfg_q    <= DYN_INIT;
            r_stat_cfg_q   <= STAT_INIT;
            r_rx_ready_q   <= 1'b0;
            r_ser_rst_n_q  <= 1'b0;
            r_flag_start_q <= 1'b0;
            r_frame_ok_q   <= 1'b0;
            r_frame_err_q  <= 1'b0;
            r_err_code_q   <= c_ERR_OK;
        end else begin
            r_state_q      <= w_state_d;
            r_idx_q        <= w_idx_d;
            r_xor_q        <= w_xor_d;
            r_shift_q      <= w_shift_d;
            r_gap_q        <= w_gap_d;
            r_arm_q        <= w_arm_d;
            r_done_cnt_q   <= w_done_cnt_d;
            r_sync_q       <= w_sync_d;
            r_dyn_cfg_q    <= w_dyn_cfg_d;
            r_stat_cfg_q   <= w_stat_cfg_d;
            r_rx_ready_q   <= w_rx_ready_d;
            r_ser_rst_n_q  <= w_ser_rst_n_d;
            r_flag_start_q <= w_flag_start_d;
            r_frame_ok_q   <= w_frame_ok_d;
            r_frame_err_q  <= w_frame_err_d;
            r_err_code_q   <= w_err_code_d;
        end
    end

    assign bus.RX_READY   = r_rx_ready_q;
    assign bus.DYN_CFG    = r_dyn_cfg_q;
    assign bus.STAT_CFG   = r_stat_cfg_q;
    assign bus.SER_RST_N  = r_ser_rst_n_q;
    assign bus.FLAG_START = r_flag_start_q;
    assign bus.BUSY       = (r_state_q != S_IDLE);
    assign bus.FRAME_OK   = r_frame_ok_q;
    assign bus.FRAME_ERR  = r_frame_err_q;
    assign bus.ERR_CODE   = r_err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_frame_loader
// Description : Self-checking bench for cfg_frame_loader. A frame-level
//               timeline model predicts every output on every cycle; directed
//               frames plus literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_frame_loader;

    localparam int          BIG      = 1000000000;
    localparam int          SRC      = 16;
    localparam int          BYTE_TO  = 1024;
    localparam int          DONE_TO  = 4096;
    localparam logic [15:0] DYN_I    = 16'hABC6;
    localparam logic [87:0] STAT_I   = 88'h123456789ABCDEF1234567;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   srn_low = 0;

    cfg_frame_loader_if bus();

    cfg_frame_loader dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Timeline model: one frame record, all times are edge indices.
    // h = header accepted, c = checksum accepted, e = edge returning to IDLE.
    // ------------------------------------------------------------------
    int          first;
    int          h, c, e;
    bit          armed, ok_end;
    logic [1:0]  fin, err_prev;
    logic [15:0] dyn_old, dyn_new;
    logic [87:0] stat_old, stat_new;

    function automatic bit exp_rdy(int n);
        return (n >= first) && !(n >= c && n < e);
    endfunction
    function automatic bit exp_srn(int n);
        return (n >= first) && !(armed && n >= c + 1 && n <= c + SRC);
    endfunction
    function automatic bit exp_start(int n);
        return armed && n >= c + SRC + 1 && n < e;
    endfunction
    function automatic bit exp_busy(int n);
        return n >= h && n < e;
    endfunction
    function automatic logic [1:0] exp_err(int n);
        if (n < h) return err_prev;
        if (n < e) return 2'b00;
        return fin;
    endfunction
    function automatic logic [15:0] exp_dyn(int n);
        return (armed && n >= c + 1) ? dyn_new : dyn_old;
    endfunction
    function automatic logic [87:0] exp_stat(int n);
        return (armed && n >= c + 1) ? stat_new : stat_old;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        first = BIG; h = BIG; c = BIG; e = BIG;
        armed = 1'b0; ok_end = 1'b0; fin = 2'b00; err_prev = 2'b00;
        dyn_old = DYN_I; stat_old = STAT_I;
        dyn_new = DYN_I; stat_new = STAT_I;
        bus.RX_VALID = 1'b0; bus.RX_DATA = 8'h00; bus.FLAG_DONE = 1'b0;
    endtask

    // Fold the finished record into the "before next header" values.
    task automatic commit();
        if (armed) begin
            dyn_old  = dyn_new;
            stat_old = stat_new;
        end
        if (e != BIG) err_prev = fin;
        else if (h != BIG) err_prev = 2'b00;
    endtask

    // Per-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            chk("rx_ready",   bus.RX_READY,   exp_rdy(cyc));
            chk("ser_rst_n",  bus.SER_RST_N,  exp_srn(cyc));
            chk("flag_start", bus.FLAG_START, exp_start(cyc));
            chk("busy",       bus.BUSY,       exp_busy(cyc));
            chk("frame_ok",   bus.FRAME_OK,   ok_end && cyc == e);
            chk("frame_err",  bus.FRAME_ERR,  !ok_end && cyc == e);
            chk("err_code",   bus.ERR_CODE,   exp_err(cyc));
            chk("dyn_cfg",    bus.DYN_CFG,    exp_dyn(cyc));
            chk("stat_cfg",   bus.STAT_CFG,   exp_stat(cyc));
            if (!bus.SER_RST_N && cyc >= first) srn_low++;
        end
    end

    // Present a byte at a negedge and wait (bounded) until it will be taken
    // on the next edge; acc is that edge index.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int k;
        k = 0;
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        while (!bus.RX_READY && k < 40) begin
            @(negedge CLK);
            k++;
        end
        if (bus.RX_READY) begin
            acc = cyc + 1;
        end else begin
            acc = -1;
            n_vec++;
            n_bad++;
            $display("FAIL rx_ready_wait cyc=%0d got=0 expected=1", cyc);
        end
    endtask

    task automatic send_garbage(input logic [7:0] b);
        int acc;
        send_byte(b, acc);
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
    endtask

    // Sends the first nb bytes of fr (MSB first) and updates the model.
    task automatic send_frame(input logic [127:0] fr, input int nb);
        int         acc;
        logic [7:0] x;
        for (int i = 0; i < nb; i++) begin
            send_byte(fr[127-8*i -: 8], acc);
            if (acc < 0) begin
                bus.RX_VALID = 1'b0;
                return;
            end
            if (i == 0) begin
                commit();
                h = acc; c = BIG; armed = 1'b0; ok_end = 1'b0; fin = 2'b11;
            end
            if (i < 15) begin
                e = acc + BYTE_TO + 1;
            end else begin
                c = acc;
                x = 8'h00;
                for (int k = 1; k <= 14; k++) x = x ^ fr[127-8*k -: 8];
                if (fr[119:112] != 8'h01) begin
                    e = c + 1; fin = 2'b01;
                end else if (x != fr[7:0]) begin
                    e = c + 1; fin = 2'b10;
                end else begin
                    armed = 1'b1; dyn_new = fr[111:96]; stat_new = fr[95:8];
                    e = c + 1 + SRC + 1 + DONE_TO; fin = 2'b11;
                end
            end
            @(negedge CLK);
        end
        bus.RX_VALID = 1'b0;
    endtask

    function automatic logic [127:0] mk_frame(input logic [15:0] dyn, input logic [87:0] stat);
        logic [127:0] f;
        logic [7:0]   x;
        f = {8'hA5, 8'h01, dyn, stat, 8'h00};
        x = 8'h00;
        for (int k = 1; k <= 14; k++) x = x ^ f[127-8*k -: 8];
        f[7:0] = x;
        return f;
    endfunction

    // FLAG_DONE rises after edge cyc: two sync flops, then the decision edge.
    task automatic raise_done();
        bus.FLAG_DONE = 1'b1;
        if (cyc + 3 < e) begin
            e = cyc + 3; ok_end = 1'b1; fin = 2'b00;
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge CLK);
    endtask

    task automatic release_reset();
        RST = 1'b0;
        first = cyc + 1;
        @(negedge CLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    logic [127:0] f;

    initial begin
        model_reset();
        wait_cycles(3);
        chk("lit_reset_ready", bus.RX_READY, 1'b0);
        chk("lit_reset_srn",   bus.SER_RST_N, 1'b0);
        chk("lit_reset_dyn",   bus.DYN_CFG, 16'hABC6);
        chk("lit_reset_err",   bus.ERR_CODE, 2'b00);
        release_reset();
        chk("lit_post_rst_ready", bus.RX_READY, 1'b1);
        chk("lit_post_rst_srn",   bus.SER_RST_N, 1'b1);

        // Garbage in IDLE, then a frame that stalls after five bytes.
        send_garbage(8'h00);
        send_garbage(8'hFF);
        send_garbage(8'h5A);
        chk("lit_garbage_busy", bus.BUSY, 1'b0);
        send_frame({8'hA5, 8'h01, 8'h12, 8'h34, 8'h00, 88'h0}, 5);
        wait_cycles(BYTE_TO + 4);
        chk("lit_gap_err",   bus.ERR_CODE, 2'b11);
        chk("lit_gap_ready", bus.RX_READY, 1'b1);
        chk("lit_gap_busy",  bus.BUSY, 1'b0);

        // Bad checksum.
        srn_low = 0;
        send_frame({8'hA5, 8'h01, 16'h1234, 88'h0, 8'h26}, 16);
        wait_cycles(3);
        chk("lit_chk_err",  bus.ERR_CODE, 2'b10);
        chk("lit_chk_dyn",  bus.DYN_CFG, 16'hABC6);
        chk("lit_chk_stat", bus.STAT_CFG, 88'h123456789ABCDEF1234567);
        chk("lit_chk_srn",  srn_low, 0);

        // Bad command with a consistent checksum.
        send_frame({8'hA5, 8'h02, 16'h1234, 88'h0, 8'h24}, 16);
        wait_cycles(3);
        chk("lit_cmd_err", bus.ERR_CODE, 2'b01);
        chk("lit_cmd_dyn", bus.DYN_CFG, 16'hABC6);

        // Valid frame, done 1000 cycles after start.
        srn_low = 0;
        send_frame({8'hA5, 8'h01, 16'h1234, 88'h0, 8'h27}, 16);
        wait_cycles(SRC + 1);
        chk("lit_ok_start", bus.FLAG_START, 1'b1);
        chk("lit_ok_dyn",   bus.DYN_CFG, 16'h1234);
        chk("lit_ok_stat",  bus.STAT_CFG, 88'h0);
        chk("lit_ok_srn16", srn_low, 16);
        wait_cycles(1000);
        raise_done();
        wait_cycles(3);
        chk("lit_ok_pulse", bus.FRAME_OK, 1'b1);
        chk("lit_ok_flag",  bus.FLAG_START, 1'b0);
        chk("lit_ok_err",   bus.ERR_CODE, 2'b00);
        bus.FLAG_DONE = 1'b0;
        wait_cycles(5);

        // Valid frame, done never comes.
        f = mk_frame(16'h5678, 88'h0102030405060708090A0B);
        send_frame(f, 16);
        wait_cycles(SRC + 1 + DONE_TO + 3);
        chk("lit_dto_err",  bus.ERR_CODE, 2'b11);
        chk("lit_dto_flag", bus.FLAG_START, 1'b0);
        chk("lit_dto_dyn",  bus.DYN_CFG, 16'h5678);

        // Reset while arming; header value used as payload data.
        f = mk_frame(16'hA5A5, 88'hA5_0000_0000_0000_0000_00A5);
        send_frame(f, 16);
        wait_cycles(5);
        RST = 1'b1;
        model_reset();
        #1;
        chk("lit_arm_rst_srn",  bus.SER_RST_N, 1'b0);
        chk("lit_arm_rst_dyn",  bus.DYN_CFG, 16'hABC6);
        chk("lit_arm_rst_busy", bus.BUSY, 1'b0);
        wait_cycles(2);
        release_reset();

        f = mk_frame(16'hA5A5, 88'hA5_0000_0000_0000_0000_00A5);
        send_frame(f, 16);
        wait_cycles(SRC + 1 + 50);
        raise_done();
        wait_cycles(3);
        chk("lit_rearm_ok",  bus.FRAME_OK, 1'b1);
        chk("lit_rearm_dyn", bus.DYN_CFG, 16'hA5A5);
        bus.FLAG_DONE = 1'b0;
        wait_cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Upstream feeder of the 2 MHz DYNCNF/STATCNF serializer.
- Receives a byte-stream configuration frame from the host bridge and validates header, command and checksum.
- On a valid frame it latches the 16-bit DYNCNF and 88-bit STATCNF words, re-arms the serializer through its reset, raises the start flag and waits for the serializer's done flag.
- Reports success, error or timeout to the host side.

Parameters:
- HEADER, 8'hA5, frame start byte.
- CMD_LOAD, 8'h01, only accepted command.
- DYN_INIT, 16'hABC6, reset value of DYN_CFG.
- STAT_INIT, 88'h123456789ABCDEF1234567, reset value of STAT_CFG.
- SER_RST_CYCLES, 16, CLK cycles SER_RST_N is held low before start.
- BYTE_TIMEOUT, 1024, max CLK cycles between accepted bytes within a frame.
- DONE_TIMEOUT, 4096, max CLK cycles from FLAG_START rise to synchronised FLAG_DONE.

Ports:
- CLK  in  1  system clock, faster than the 2 MHz serializer clock.
- RST  in  1  asynchronous reset, active-high.
- RX_DATA  in  8  frame byte from host bridge.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader accepts a byte this cycle.
- FLAG_DONE  in  1  serializer done flag (2 MHz domain, level).
- DYN_CFG  out  16  DYNCNF word to serializer.
- STAT_CFG  out  88  STATCNF word to serializer.
- SER_RST_N  out  1  active-low reset to serializer.
- FLAG_START  out  1  start level to serializer.
- BUSY  out  1  frame in progress (any state except IDLE).
- FRAME_OK  out  1  one-cycle pulse, transfer completed.
- FRAME_ERR  out  1  one-cycle pulse, frame rejected or timed out.
- ERR_CODE  out  2  00 ok, 01 bad command, 10 checksum, 11 timeout; sticky until next HEADER accepted.

Behaviour:
- Reset values:
  - RX_READY=0, SER_RST_N=0, FLAG_START=0, BUSY=0, FRAME_OK=0, FRAME_ERR=0, ERR_CODE=00.
  - DYN_CFG=DYN_INIT, STAT_CFG=STAT_INIT.
  - State IDLE, all counters 0.
- First CLK edge after RST falls: SER_RST_N=1, RX_READY=1.
- A byte is accepted when RX_VALID && RX_READY.
- FLAG_DONE passes through a 2-flop synchroniser; only the synchronised value (done_s) is used.
- Frame format, 16 bytes, MSB first:
  - HEADER, CMD, DYN[15:8], DYN[7:0], STAT[87:80] through STAT[7:0], CHK.
  - CHK = XOR of CMD and the 13 payload bytes; HEADER is excluded.
- States:
  - IDLE: RX_READY=1. Accepted bytes other than HEADER are discarded. Accepting HEADER clears ERR_CODE and the byte index and moves to RECV.
  - RECV: RX_READY=1.
    - Accepted bytes are stored into shadow registers (not the outputs) and folded into a running XOR. A HEADER value here is treated as data.
    - The byte-gap counter resets on every accepted byte.
    - If the counter reaches BYTE_TIMEOUT: ERR_CODE=11, FRAME_ERR pulse, go to IDLE.
    - After the 15th post-header byte (CHK) is accepted, go to CHECK.
  - CHECK, 1 cycle: RX_READY=0.
    - CMD!=CMD_LOAD: ERR_CODE=01, FRAME_ERR, go to IDLE.
    - Otherwise XOR!=CHK: ERR_CODE=10, FRAME_ERR, go to IDLE.
    - Otherwise copy shadows to DYN_CFG/STAT_CFG and go to ARM.
    - Outputs never change on a rejected frame.
  - ARM: SER_RST_N=0 for exactly SER_RST_CYCLES CLK cycles, then SER_RST_N=1 and go to START. done_s is ignored in ARM.
  - START:
    - FLAG_START=1 from the first START cycle. The done counter runs from 0.
    - done_s=1: FLAG_START=0, FRAME_OK pulse, ERR_CODE=00, go to IDLE.
    - Counter reaches DONE_TIMEOUT: FLAG_START=0, ERR_CODE=11, FRAME_ERR, go to IDLE.
    - If done_s and the timeout fire in the same cycle, done wins.
- FRAME_OK and FRAME_ERR are never asserted together and are each exactly one cycle wide.
- SER_RST_N stays 1 after completion. The serializer's done flag stays latched until the next ARM.
- Async RST in any state aborts immediately to reset values. DYN_CFG/STAT_CFG return to their INIT values.
- Counters saturate and never wrap; widths are sized by $clog2 of the corresponding parameter + 1.

Test Plan:
- Valid frame A5 01 12 34, 11×00, CHK 27 -> DYN_CFG=16'h1234, STAT_CFG=0, SER_RST_N low exactly 16 cycles, FLAG_START high; FLAG_DONE driven high 1000 cycles later -> FRAME_OK pulse ~3 cycles later, FLAG_START=0, ERR_CODE=00.
- Same frame with CHK 26 -> FRAME_ERR, ERR_CODE=10, DYN_CFG stays ABC6, STAT_CFG stays INIT, SER_RST_N never drops.
- CMD 02 with correct XOR (CHK 24) -> ERR_CODE=01, FRAME_ERR, outputs unchanged.
- Garbage bytes 00 FF 5A before a valid frame, then stall RX_VALID 1024 cycles after byte 5 -> garbage ignored, timeout gives ERR_CODE=11, back in IDLE with RX_READY=1.
- Valid frame with FLAG_DONE held low -> FLAG_START drops after 4096 cycles, FRAME_ERR, ERR_CODE=11.
- RST pulsed during ARM -> SER_RST_N=0, DYN_CFG=ABC6, BUSY=0; a following valid frame completes normally.
